// File: rtl/cpu_ctrl.sv
// cpu_ctrl: multi-cycle instruction sequencer (fetch/decode/exec/mem/wb)
// with a sticky trap on illegal opcodes and a retired-instruction counter.
module cpu_ctrl #(
  parameter int unsigned RCNT_W = 32
) (
  input  logic              clk,
  input  logic              nreset,
  output logic              imem_req,
  input  logic              imem_ack,
  input  logic [31:0]       instr,
  output logic [31:0]       ir,
  output logic              dmem_req,
  output logic              dmem_we,
  input  logic              dmem_ack,
  output logic              regw,
  output logic              pc_en,
  output logic              illegal,
  output logic [2:0]        state,
  output logic [RCNT_W-1:0] retired
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_TRAP   = 3'd5
  } state_e;

  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_IMM   = 7'b0010011;
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;

  state_e            state_q, state_d;
  logic [31:0]       ir_q, ir_d;
  logic [RCNT_W-1:0] retired_q, retired_d;

  logic is_load, is_store, is_legal;
  logic imem_req_c, dmem_req_c, dmem_we_c, regw_c, pc_en_c;

  // Opcode class decode from the instruction register
  always_comb begin
    is_load  = (ir_q[6:0] == OP_LOAD);
    is_store = (ir_q[6:0] == OP_STORE);
    is_legal = (ir_q[6:0] == OP_R) || (ir_q[6:0] == OP_IMM) || is_load || is_store;
  end

  // Next-state and Moore outputs; only store retirement looks at dmem_ack
  always_comb begin
    state_d    = state_q;
    ir_d       = ir_q;
    imem_req_c = 1'b0;
    dmem_req_c = 1'b0;
    dmem_we_c  = 1'b0;
    regw_c     = 1'b0;
    pc_en_c    = 1'b0;
    case (state_q)
      S_FETCH: begin
        imem_req_c = 1'b1;
        if (imem_ack) begin
          ir_d    = instr;
          state_d = S_DECODE;
        end
      end
      S_DECODE: state_d = is_legal ? S_EXEC : S_TRAP;
      S_EXEC:   state_d = (is_load || is_store) ? S_MEM : S_WB;
      S_MEM: begin
        dmem_req_c = 1'b1;
        dmem_we_c  = is_store;
        if (dmem_ack) begin
          if (is_store) begin
            pc_en_c = 1'b1;
            state_d = S_FETCH;
          end else begin
            state_d = S_WB;
          end
        end
      end
      S_WB: begin
        regw_c  = 1'b1;
        pc_en_c = 1'b1;
        state_d = S_FETCH;
      end
      S_TRAP:  state_d = S_TRAP;
      default: state_d = S_FETCH;
    endcase
  end

  // Retired counter advances once per retirement strobe, wrapping naturally
  always_comb begin
    retired_d = retired_q + RCNT_W'(pc_en_c);
  end

  // State, instruction register and counter flops
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      state_q   <= S_FETCH;
      ir_q      <= '0;
      retired_q <= '0;
    end else begin
      state_q   <= state_d;
      ir_q      <= ir_d;
      retired_q <= retired_d;
    end
  end

  // Reset state is FETCH, so outputs are gated to stay quiet while nreset is low
  always_comb begin
    imem_req = nreset & imem_req_c;
    dmem_req = nreset & dmem_req_c;
    dmem_we  = nreset & dmem_we_c;
    regw     = nreset & regw_c;
    pc_en    = nreset & pc_en_c;
    illegal  = (state_q == S_TRAP);
    state    = state_q;
    ir       = ir_q;
    retired  = retired_q;
  end

endmodule

// File: tb/tb_cpu_ctrl.sv
// Scoreboard bench for cpu_ctrl: the driver pushes the expected retirement
// record for each instruction; a negedge monitor pops and checks it at pc_en.
module tb_cpu_ctrl;

  localparam int unsigned RW = 4;

  logic          clk = 1'b0;
  logic          nreset;
  logic          imem_req, imem_ack;
  logic [31:0]   instr, ir;
  logic          dmem_req, dmem_we, dmem_ack;
  logic          regw, pc_en, illegal;
  logic [2:0]    state;
  logic [RW-1:0] retired;

  cpu_ctrl #(.RCNT_W(RW)) dut (
    .clk      (clk),
    .nreset   (nreset),
    .imem_req (imem_req),
    .imem_ack (imem_ack),
    .instr    (instr),
    .ir       (ir),
    .dmem_req (dmem_req),
    .dmem_we  (dmem_we),
    .dmem_ack (dmem_ack),
    .regw     (regw),
    .pc_en    (pc_en),
    .illegal  (illegal),
    .state    (state),
    .retired  (retired)
  );

  always #5 clk = ~clk;

  int unsigned n_chk  = 0;
  int unsigned n_pass = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  typedef struct {
    logic [31:0]   w;
    logic [31:0]   trace;
    int unsigned   lat;
    int unsigned   memc;
    logic          we;
    int unsigned   regwc;
    logic [RW-1:0] ret;
  } exp_t;

  exp_t          sb_q[$];
  logic [RW-1:0] ret_model = '0;
  logic          start_tog = 1'b0;
  logic          start_seen = 1'b0;

  int unsigned m_lat = 0, m_memc = 0, m_regwc = 0, excl_bad = 0;
  logic        m_we = 1'b0;
  logic [31:0] m_trace = '0;

  // Monitor: accumulate per-instruction observations, compare on pc_en
  always @(negedge clk) begin
    exp_t e;
    if (!nreset || (start_tog != start_seen)) begin
      m_lat = 0; m_memc = 0; m_regwc = 0; m_we = 1'b0; m_trace = '0;
      start_seen = start_tog;
    end
    if (nreset && state != 3'd5) begin
      if (imem_req && dmem_req) excl_bad++;
      m_lat++;
      m_trace = {m_trace[27:0], 1'b0, state};
      m_memc += 32'(dmem_req);
      m_regwc += 32'(regw);
      m_we = m_we | (dmem_req & dmem_we);
      if (pc_en) begin
        if (sb_q.size() == 0) begin
          check("sb_unexpected_pc_en", 32'(sb_q.size()), 32'd1);
        end else begin
          e = sb_q.pop_front();
          check("ir",          ir,             e.w);
          check("latency",     m_lat,          e.lat);
          check("state_trace", m_trace,        e.trace);
          check("mem_cycles",  m_memc,         e.memc);
          check("dmem_we",     32'(m_we),      32'(e.we));
          check("regw_cycles", m_regwc,        e.regwc);
          check("retired",     32'(retired),   32'(e.ret));
        end
        m_lat = 0; m_memc = 0; m_regwc = 0; m_we = 1'b0; m_trace = '0;
      end
    end
  end

  // Drive one instruction: iw fetch wait cycles, dw data wait cycles
  task automatic issue(input logic [31:0] w, input int unsigned iw, input int unsigned dw);
    exp_t        e;
    logic        is_ld, is_st, done;
    int unsigned mc;
    is_ld = (w[6:0] == 7'b0000011);
    is_st = (w[6:0] == 7'b0100011);
    e.w = w;
    e.trace = 32'h12;
    if (is_ld || is_st) begin
      for (int unsigned k = 0; k <= dw; k++) e.trace = {e.trace[27:0], 4'h3};
      if (is_ld) e.trace = {e.trace[27:0], 4'h4};
      e.lat  = iw + dw + (is_ld ? 5 : 4);
      e.memc = dw + 1;
    end else begin
      e.trace = {e.trace[27:0], 4'h4};
      e.lat  = iw + 4;
      e.memc = 0;
    end
    e.we    = is_st;
    e.regwc = is_st ? 0 : 1;
    e.ret   = ret_model;
    ret_model = ret_model + 1'b1;
    sb_q.push_back(e);

    for (int unsigned k = 0; k <= iw; k++) begin
      @(posedge clk); #1;
      if (k == 0) start_tog = ~start_tog;
      imem_ack = (k == iw);
      instr    = (k == iw) ? w : ~w;
      dmem_ack = 1'b1;
    end
    done = 1'b0;
    mc   = 0;
    for (int n = 0; n < 40 && !done; n++) begin
      @(posedge clk); #1;
      imem_ack = (state == 3'd1) || (state == 3'd2) || (state == 3'd3);
      instr    = ~w;
      if (dmem_req) begin
        dmem_ack = (mc == dw);
        mc++;
      end else begin
        dmem_ack = (state == 3'd2);
      end
      @(negedge clk);
      if (pc_en) done = 1'b1;
    end
    if (!done) check("retire_timeout", 32'(done), 32'd1);
  endtask

  task automatic do_reset();
    @(posedge clk); #2;
    nreset   = 1'b0;
    imem_ack = 1'b0;
    dmem_ack = 1'b0;
    #1;
    check("rst_outputs", {24'd0, state, illegal, imem_req, dmem_req, dmem_we, regw, pc_en}, 32'd0);
    check("rst_ir", ir, 32'd0);
    check("rst_retired", 32'(retired), 32'd0);
    check("sb_drained", 32'(sb_q.size()), 32'd0);
    @(posedge clk); #2;
    nreset = 1'b1;
    @(posedge clk); #1;
    check("post_rst_fetch", {28'd0, state, imem_req}, {28'd0, 3'd0, 1'b1});
    ret_model = '0;
  endtask

  initial begin
    nreset   = 1'b1;
    imem_ack = 1'b0;
    dmem_ack = 1'b0;
    instr    = '0;
    #1 nreset = 1'b0;
    do_reset();

    issue(32'h002081B3, 0, 0);   // R, zero wait
    issue(32'h0000A103, 0, 3);   // LOAD, ack after 3 waits
    issue(32'h0020A023, 0, 0);   // STORE, immediate ack
    issue(32'h00108093, 2, 0);   // IMM with fetch wait
    issue(32'h0000A103, 1, 0);   // LOAD, zero data wait
    issue(32'h0020A023, 0, 2);   // STORE with data wait

    do_reset();
    for (int i = 0; i < 16; i++) issue(32'h00108093, 0, 0);
    @(posedge clk); #1;
    check("retired_wrap", 32'(retired), 32'd0);

    // Illegal opcode: DECODE then sticky TRAP, acks held high and ignored
    imem_ack = 1'b1;
    instr    = 32'h0000007F;
    dmem_ack = 1'b1;
    @(posedge clk); #1;
    check("trap_decode", {29'd0, state}, 32'd1);
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      check("trap_hold", {22'd0, illegal, imem_req, dmem_req, regw, pc_en, state, 2'b00},
            {22'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'd5, 2'b00});
    end
    check("trap_retired", 32'(retired), 32'(ret_model));

    // Reset asserted mid-MEM with an ack pending
    do_reset();
    imem_ack = 1'b1;
    instr    = 32'h0000A103;
    dmem_ack = 1'b0;
    for (int n = 0; n < 10; n++) begin
      @(posedge clk); #1;
      imem_ack = 1'b0;
      if (dmem_req) break;
    end
    check("mem_reached", 32'(dmem_req), 32'd1);
    #2 dmem_ack = 1'b1;
    #1 nreset = 1'b0;
    #1;
    check("async_drop", {28'd0, dmem_req, state}, 32'd0);
    check("async_ir", ir, 32'd0);
    dmem_ack = 1'b0;
    @(posedge clk); #2;
    nreset = 1'b1;
    @(posedge clk); #1;
    check("release_state", {28'd0, state, imem_req}, {28'd0, 3'd0, 1'b1});
    check("release_ir", ir, 32'd0);

    check("req_exclusive", excl_bad, 32'd0);
    check("sb_final", 32'(sb_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
